// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl_pkg : shared types for the RV32I stall/flush controller
// Revision: 1.0
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MP_IDLE = 2'd0,
    MP_WAIT = 2'd1,
    MP_DONE = 2'd2
  } memport_state_t;

  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_STALL  = 3'd1,
    ACT_FLUSH  = 3'd2,
    ACT_BUBBLE = 3'd3,
    ACT_RUN    = 3'd4
  } hazard_act_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } buf_ctrl_t;

  function automatic logic src_hit(input logic uses, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return uses & (rs == rd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl_if : cache handshake between datapath and controller
// Revision: 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if;
  logic imem_req;
  logic imem_resp;
  logic imem_read;
  logic ir_latch;
  logic ir_use_latched;
  logic dmem_req;
  logic dmem_resp;
  logic dmem_en;

  modport master (
    output imem_req, imem_resp, dmem_req, dmem_resp,
    input  imem_read, ir_latch, ir_use_latched, dmem_en
  );

  modport slave (
    input  imem_req, imem_resp, dmem_req, dmem_resp,
    output imem_read, ir_latch, ir_use_latched, dmem_en
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_memport_tracker.sv
`default_nettype none
// ============================================================================
// memport_tracker : remembers a cache response received while the other port
//                   still stalls the pipeline. Revision: 1.0
// ============================================================================
module memport_tracker
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           req,
  input  logic           resp,
  input  logic           other_pend,
  output logic           pend,
  output logic           strobe,
  output memport_state_t state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MP_IDLE;
    end else begin
      case (state)
        MP_IDLE: begin
          // A response arriving with the request is treated exactly like WAIT
          if (req) begin
            if (resp) state <= other_pend ? MP_DONE : MP_IDLE;
            else      state <= MP_WAIT;
          end
        end
        MP_WAIT: begin
          if (resp) state <= other_pend ? MP_DONE : MP_IDLE;
        end
        MP_DONE: begin
          if (!other_pend) state <= MP_IDLE;
        end
        default: state <= MP_IDLE;
      endcase
    end
  end

  assign pend   = req & ~resp & (state != MP_DONE);
  assign strobe = ~reset & req & (state != MP_DONE);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : stall/flush/PC-enable control for the 5-stage pipe
// Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  mem,
  input  logic                   EX_memread,
  input  logic [4:0]             EX_rd_num,
  input  logic [4:0]             ID_rs1_num,
  input  logic [4:0]             ID_rs2_num,
  input  logic                   ID_uses_rs1,
  input  logic                   ID_uses_rs2,
  input  logic                   EX_br_taken,
  output logic                   pc_load,
  output logic                   stall_IF_ID,
  output logic                   stall_ID_EX,
  output logic                   stall_EX_MEM,
  output logic                   stall_MEM_WB,
  output logic                   clear_IF_ID,
  output logic                   clear_ID_EX,
  output logic                   clear_EX_MEM,
  output logic                   clear_MEM_WB,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       bubble_count,
  output logic [CNT_W-1:0]       flush_count
);

  logic           i_pend, d_pend, mem_stall, load_use;
  memport_state_t istate, dstate;
  hazard_act_t    act;
  buf_ctrl_t      stall_v, clear_v;

  memport_tracker u_itrk (
    .clk(clk), .reset(reset), .req(mem.imem_req), .resp(mem.imem_resp),
    .other_pend(d_pend), .pend(i_pend), .strobe(mem.imem_read), .state(istate)
  );

  memport_tracker u_dtrk (
    .clk(clk), .reset(reset), .req(mem.dmem_req), .resp(mem.dmem_resp),
    .other_pend(i_pend), .pend(d_pend), .strobe(mem.dmem_en), .state(dstate)
  );

  assign mem_stall = i_pend | d_pend;

  // Latch when the I tracker will move to DONE, including a same-cycle IDLE hit
  assign mem.ir_latch = ~reset & mem.imem_resp & d_pend &
                        ((istate == MP_WAIT) | ((istate == MP_IDLE) & mem.imem_req));
  assign mem.ir_use_latched = ~reset & (istate == MP_DONE);

  assign load_use = EX_memread & (EX_rd_num != 5'd0) &
                    (src_hit(ID_uses_rs1, ID_rs1_num, EX_rd_num) |
                     src_hit(ID_uses_rs2, ID_rs2_num, EX_rd_num));

  always_comb begin
    act     = ACT_RUN;
    stall_v = '0;
    clear_v = '0;
    pc_load = 1'b0;
    if (reset) begin
      act     = ACT_RESET;
      clear_v = '1;
    end else if (mem_stall) begin
      act     = ACT_STALL;
      stall_v = '1;
    end else if (EX_br_taken) begin
      act           = ACT_FLUSH;
      clear_v.if_id = 1'b1;
      clear_v.id_ex = 1'b1;
      pc_load       = 1'b1;
    end else if (load_use) begin
      act           = ACT_BUBBLE;
      stall_v.if_id = 1'b1;
      clear_v.id_ex = 1'b1;
    end else begin
      pc_load = 1'b1;
    end
  end

  assign {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = stall_v;
  assign {clear_IF_ID, clear_ID_EX, clear_EX_MEM, clear_MEM_WB} = clear_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      stall_cycles <= stall_cycles + CNT_W'(act == ACT_STALL);
      bubble_count <= bubble_count + CNT_W'(act == ACT_BUBBLE);
      flush_count  <= flush_count  + CNT_W'(act == ACT_FLUSH);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl : directed + random checks against a behavioural
//                           model of the stall/flush controller. Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_memread, ID_uses_rs1, ID_uses_rs2, EX_br_taken;
  logic [4:0]  EX_rd_num, ID_rs1_num, ID_rs2_num;
  logic        pc_load;
  logic        stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic        clear_IF_ID, clear_ID_EX, clear_EX_MEM, clear_MEM_WB;
  logic [31:0] stall_cycles, bubble_count, flush_count;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .mem(hif),
    .EX_memread(EX_memread), .EX_rd_num(EX_rd_num),
    .ID_rs1_num(ID_rs1_num), .ID_rs2_num(ID_rs2_num),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_br_taken(EX_br_taken), .pc_load(pc_load),
    .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .clear_IF_ID(clear_IF_ID), .clear_ID_EX(clear_ID_EX),
    .clear_EX_MEM(clear_EX_MEM), .clear_MEM_WB(clear_MEM_WB),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a port "has its answer" once its response came while the other
  // port still blocked the pipe; it forgets it once the pipe moves again.
  bit          m_igot, m_dgot;
  bit          i_out, d_out;
  logic [31:0] m_sc, m_bub, m_fl;
  int          mode;
  bit          ip, dp, ms;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    bit lu;
    logic [3:0] es, ec, ast, acl;
    #3;
    ip = hif.imem_req && !hif.imem_resp && !m_igot;
    dp = hif.dmem_req && !hif.dmem_resp && !m_dgot;
    ms = ip || dp;
    lu = EX_memread && (EX_rd_num != 0) &&
         ((ID_uses_rs1 && ID_rs1_num == EX_rd_num) || (ID_uses_rs2 && ID_rs2_num == EX_rd_num));
    if (reset) mode = 0;
    else if (ms) mode = 1;
    else if (EX_br_taken) mode = 2;
    else if (lu) mode = 3;
    else mode = 4;
    es  = (mode == 1) ? 4'hF : (mode == 3) ? 4'h8 : 4'h0;
    ec  = (mode == 0) ? 4'hF : (mode == 2) ? 4'hC : (mode == 3) ? 4'h4 : 4'h0;
    ast = {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB};
    acl = {clear_IF_ID, clear_ID_EX, clear_EX_MEM, clear_MEM_WB};
    chk("stall_vec", 32'(ast), 32'(es));
    chk("clear_vec", 32'(acl), 32'(ec));
    chk("stall_and_clear", 32'(ast & acl), 32'd0);
    chk("pc_load", 32'(pc_load), 32'(mode == 2 || mode == 4));
    chk("imem_read", 32'(hif.imem_read), 32'(!reset && hif.imem_req && !m_igot));
    chk("dmem_en", 32'(hif.dmem_en), 32'(!reset && hif.dmem_req && !m_dgot));
    chk("ir_latch", 32'(hif.ir_latch),
        32'(!reset && hif.imem_resp && hif.imem_req && !m_igot && dp));
    chk("ir_use_latched", 32'(hif.ir_use_latched), 32'(!reset && m_igot));
    chk("stall_cycles", stall_cycles, m_sc);
    chk("bubble_count", bubble_count, m_bub);
    chk("flush_count", flush_count, m_fl);
  endtask

  task automatic advance();
    bit ig_n, dg_n, io_n, do_n;
    if (reset) begin
      ig_n = 0; dg_n = 0; io_n = 0; do_n = 0;
    end else begin
      ig_n = m_igot ? dp : (hif.imem_req && hif.imem_resp && dp);
      dg_n = m_dgot ? ip : (hif.dmem_req && hif.dmem_resp && ip);
      io_n = !m_igot && (i_out || hif.imem_req) && !hif.imem_resp;
      do_n = !m_dgot && (d_out || hif.dmem_req) && !hif.dmem_resp;
    end
    @(posedge clk);
    if (reset) begin
      m_sc = 0; m_bub = 0; m_fl = 0;
    end else begin
      m_sc  = m_sc  + 32'(mode == 1);
      m_fl  = m_fl  + 32'(mode == 2);
      m_bub = m_bub + 32'(mode == 3);
    end
    m_igot = ig_n; m_dgot = dg_n; i_out = io_n; d_out = do_n;
    #1;
  endtask

  task automatic quiet();
    hif.imem_req = 0; hif.imem_resp = 0; hif.dmem_req = 0; hif.dmem_resp = 0;
    EX_memread = 0; EX_rd_num = 0; ID_rs1_num = 0; ID_rs2_num = 0;
    ID_uses_rs1 = 0; ID_uses_rs2 = 0; EX_br_taken = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; settle(); advance(); reset = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    EX_memread = 1; EX_rd_num = rd; ID_rs2_num = 5'd5; ID_uses_rs2 = 1;
  endtask

  initial begin
    quiet();
    reset = 1;
    m_igot = 0; m_dgot = 0; i_out = 0; d_out = 0; m_sc = 0; m_bub = 0; m_fl = 0;
    @(posedge clk); #1;
    settle();
    chk("reset_clear_IF_ID", 32'(clear_IF_ID), 32'd1);
    advance(); reset = 0;
    quiet(); settle();
    chk("reset_stall_cycles", stall_cycles, 32'd0);
    chk("idle_pc_load", 32'(pc_load), 32'd1);
    advance();

    // Icache miss, response on cycle 3
    do_reset();
    for (int c = 0; c < 4; c++) begin
      hif.imem_req = 1; hif.imem_resp = (c == 3);
      settle();
      if (c < 3) chk("imiss_stall", 32'(stall_MEM_WB), 32'd1);
      else       chk("imiss_release_pc", 32'(pc_load), 32'd1);
      advance();
    end
    quiet(); settle();
    chk("imiss_stall_cycles", stall_cycles, 32'd3);
    advance();

    // Overlapping I/D misses: I answers on 2, D on 5
    do_reset();
    for (int c = 0; c < 7; c++) begin
      hif.imem_req = (c < 6); hif.dmem_req = (c < 6);
      hif.imem_resp = (c == 2); hif.dmem_resp = (c == 5);
      settle();
      if (c == 2) chk("ovl_ir_latch", 32'(hif.ir_latch), 32'd1);
      if (c >= 3 && c <= 5) begin
        chk("ovl_imem_read", 32'(hif.imem_read), 32'd0);
        chk("ovl_use_latched", 32'(hif.ir_use_latched), 32'd1);
      end
      if (c == 5) chk("ovl_release", 32'(stall_IF_ID), 32'd0);
      if (c == 6) begin
        chk("ovl_idle_use", 32'(hif.ir_use_latched), 32'd0);
        chk("ovl_stall_cycles", stall_cycles, 32'd5);
      end
      advance();
    end

    // Load-use bubble, then the same with rd = x0
    do_reset();
    set_load_use(5'd5); settle();
    chk("lu_stall_IF_ID", 32'(stall_IF_ID), 32'd1);
    chk("lu_clear_ID_EX", 32'(clear_ID_EX), 32'd1);
    chk("lu_pc_load", 32'(pc_load), 32'd0);
    advance();
    quiet(); settle();
    chk("lu_bubble_count", bubble_count, 32'd1);
    advance();
    set_load_use(5'd0); settle();
    chk("lu_x0_no_stall", 32'(stall_IF_ID), 32'd0);
    advance();
    quiet(); settle();
    chk("lu_x0_bubble_count", bubble_count, 32'd1);
    advance();

    // Branch overrides load-use
    do_reset();
    set_load_use(5'd5); EX_br_taken = 1; settle();
    chk("br_clear_IF_ID", 32'(clear_IF_ID), 32'd1);
    chk("br_pc_load", 32'(pc_load), 32'd1);
    advance();
    quiet(); settle();
    chk("br_flush_count", flush_count, 32'd1);
    chk("br_bubble_count", bubble_count, 32'd0);
    advance();

    // Reset while D waits, then a stray response
    do_reset();
    hif.dmem_req = 1; settle(); advance();
    settle(); advance();
    reset = 1; settle();
    chk("rstw_dmem_en", 32'(hif.dmem_en), 32'd0);
    advance(); reset = 0;
    quiet(); hif.dmem_resp = 1; settle();
    chk("rstw_stray_pc", 32'(pc_load), 32'd1);
    advance();
    quiet(); hif.dmem_req = 1; settle();
    chk("rstw_not_done", 32'(hif.dmem_en), 32'd1);
    chk("rstw_counter", stall_cycles, 32'd0);
    advance();
    do_reset();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (m_igot) begin
        hif.imem_req = 1'($urandom_range(0, 1)); hif.imem_resp = 0;
      end else if (i_out) begin
        hif.imem_req = 1; hif.imem_resp = ($urandom_range(0, 2) == 0);
      end else begin
        hif.imem_req = ($urandom_range(0, 2) == 0);
        hif.imem_resp = !hif.imem_req && ($urandom_range(0, 7) == 0);
      end
      if (m_dgot) begin
        hif.dmem_req = 1'($urandom_range(0, 1)); hif.dmem_resp = 0;
      end else if (d_out) begin
        hif.dmem_req = 1; hif.dmem_resp = ($urandom_range(0, 3) == 0);
      end else begin
        hif.dmem_req = ($urandom_range(0, 3) == 0);
        hif.dmem_resp = !hif.dmem_req && ($urandom_range(0, 7) == 0);
      end
      EX_memread  = 1'($urandom_range(0, 1));
      EX_rd_num   = 5'($urandom_range(0, 3));
      ID_rs1_num  = 5'($urandom_range(0, 3));
      ID_rs2_num  = 5'($urandom_range(0, 3));
      ID_uses_rs1 = 1'($urandom_range(0, 1));
      ID_uses_rs2 = 1'($urandom_range(0, 1));
      EX_br_taken = ($urandom_range(0, 5) == 0);
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
